// File: rtl/tug_field.sv
// Tug-of-War playfield: turns the human key and the computer push level into
// single move events, moves the rope along the LED row, scores round wins and
// stops the match once either player reaches the target score.
module tug_field #(
   parameter int NUM_LIGHTS  = 9,
   parameter int SCORE_MAX   = 7,
   parameter int HOLD_CYCLES = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  human_key,
   input  logic                  comp_press,
   output logic [NUM_LIGHTS-1:0] lights,
   output logic [2:0]            human_score,
   output logic [2:0]            comp_score,
   output logic                  human_win,
   output logic                  comp_win,
   output logic                  game_over
);

   localparam int POS_W  = $clog2(NUM_LIGHTS);
   localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

   localparam logic [POS_W-1:0]  CENTRE    = POS_W'(NUM_LIGHTS / 2);
   localparam logic [POS_W-1:0]  LAST      = POS_W'(NUM_LIGHTS - 1);
   localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
   localparam logic [2:0]        SCORE_TOP = 3'(SCORE_MAX);

   typedef enum logic [1:0] {
      ST_PLAY,
      ST_HOLD,
      ST_OVER
   } state_t;

   // Input conditioning flops: two synchroniser stages plus previous value.
   logic r_h_s1, r_h_s2, r_h_prev;
   logic r_c_s1, r_c_s2, r_c_prev;

   // Game state registers and their next-state values.
   state_t            r_state,  w_state_nxt;
   logic [POS_W-1:0]  r_pos,    w_pos_nxt;
   logic [HOLD_W-1:0] r_hold,   w_hold_nxt;
   logic [2:0]        r_h_score, w_h_score_nxt;
   logic [2:0]        r_c_score, w_c_score_nxt;
   logic              r_h_win,  w_h_win_nxt;
   logic              r_c_win,  w_c_win_nxt;

   logic w_h_press, w_c_press;
   logic [2:0] w_h_score_inc, w_c_score_inc;

   // Synchronise both inputs through identical paths so their latency matches.
   // NOTE: sequential state uses non-blocking (<=) so every flop samples the
   // pre-edge value of its neighbour; blocking here would collapse the chain.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_h_s1   <= 1'b0;
         r_h_s2   <= 1'b0;
         r_h_prev <= 1'b0;
         r_c_s1   <= 1'b0;
         r_c_s2   <= 1'b0;
         r_c_prev <= 1'b0;
      end else begin
         r_h_s1   <= human_key;
         r_h_s2   <= r_h_s1;
         r_h_prev <= r_h_s2;
         r_c_s1   <= comp_press;
         r_c_s2   <= r_c_s1;
         r_c_prev <= r_c_s2;
      end
   end

   // One-cycle press on each synchronised rising edge.
   assign w_h_press = r_h_s2 & ~r_h_prev;
   assign w_c_press = r_c_s2 & ~r_c_prev;

   assign w_h_score_inc = r_h_score + 3'd1;
   assign w_c_score_inc = r_c_score + 3'd1;

   // Register the game state; reset returns everything to the centred start.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= ST_PLAY;
         r_pos     <= CENTRE;
         r_hold    <= '0;
         r_h_score <= 3'd0;
         r_c_score <= 3'd0;
         r_h_win   <= 1'b0;
         r_c_win   <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_pos     <= w_pos_nxt;
         r_hold    <= w_hold_nxt;
         r_h_score <= w_h_score_nxt;
         r_c_score <= w_c_score_nxt;
         r_h_win   <= w_h_win_nxt;
         r_c_win   <= w_c_win_nxt;
      end
   end

   // Next-state logic: rope moves, round wins, dark hold and match end.
   // NOTE: every output of this block gets a default first, so no path can
   // leave a signal unassigned and infer a latch.
   always_comb begin
      w_state_nxt   = r_state;
      w_pos_nxt     = r_pos;
      w_hold_nxt    = r_hold;
      w_h_score_nxt = r_h_score;
      w_c_score_nxt = r_c_score;
      w_h_win_nxt   = 1'b0;
      w_c_win_nxt   = 1'b0;

      case (r_state)
         ST_PLAY: begin
            if (w_h_press && !w_c_press) begin
               if (r_pos == LAST) begin
                  w_h_score_nxt = w_h_score_inc;
                  w_h_win_nxt   = 1'b1;
                  if (w_h_score_inc == SCORE_TOP) begin
                     w_state_nxt = ST_OVER;
                  end else begin
                     w_state_nxt = ST_HOLD;
                     w_hold_nxt  = HOLD_LOAD;
                  end
               end else begin
                  w_pos_nxt = r_pos + POS_W'(1);
               end
            end else if (w_c_press && !w_h_press) begin
               if (r_pos == '0) begin
                  w_c_score_nxt = w_c_score_inc;
                  w_c_win_nxt   = 1'b1;
                  if (w_c_score_inc == SCORE_TOP) begin
                     w_state_nxt = ST_OVER;
                  end else begin
                     w_state_nxt = ST_HOLD;
                     w_hold_nxt  = HOLD_LOAD;
                  end
               end else begin
                  w_pos_nxt = r_pos - POS_W'(1);
               end
            end
         end
         ST_HOLD: begin
            if (r_hold == '0) begin
               w_state_nxt = ST_PLAY;
               w_pos_nxt   = CENTRE;
            end else begin
               w_hold_nxt = r_hold - HOLD_W'(1);
            end
         end
         ST_OVER: begin
            w_state_nxt = ST_OVER;
         end
         default: begin
            w_state_nxt = ST_PLAY;
            w_pos_nxt   = CENTRE;
         end
      endcase
   end

   // Outputs decode from registered state only.
   assign lights      = (r_state == ST_PLAY) ? (NUM_LIGHTS'(1) << r_pos) : '0;
   assign game_over   = (r_state == ST_OVER);
   assign human_score = r_h_score;
   assign comp_score  = r_c_score;
   assign human_win   = r_h_win;
   assign comp_win    = r_c_win;

endmodule
